// File: rtl/tetris_pkg.sv
// Shared types for the falling-piece datapath: move commands, pending-request
// flags and the move_gen FSM states, plus the issue-priority helpers.
package tetris_pkg;

  typedef enum logic [2:0] {RIGHT, LEFT, ROTATE, DOWN, NONE} move_t;

  typedef enum logic [0:0] {StIdle, StIssue} mg_state_t;

  typedef struct packed {
    logic rotate;
    logic left;
    logic right;
    logic down;
  } pend_t;

  // Fixed priority ROTATE > LEFT > RIGHT > DOWN.
  function automatic move_t pick_move(pend_t p);
    move_t m;
    if (p.rotate)     m = ROTATE;
    else if (p.left)  m = LEFT;
    else if (p.right) m = RIGHT;
    else if (p.down)  m = DOWN;
    else              m = NONE;
    return m;
  endfunction

  function automatic pend_t move_mask(move_t m);
    pend_t mask;
    mask = '0;
    case (m)
      ROTATE:  mask.rotate = 1'b1;
      LEFT:    mask.left   = 1'b1;
      RIGHT:   mask.right  = 1'b1;
      DOWN:    mask.down   = 1'b1;
      default: ;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/btn_filter.sv
// Per-button front end: 2-flop synchroniser, tick-based debounce and, when
// MOVE_GEN_AUTO_REPEAT_EN is defined, a hold counter that re-fires the press.
module btn_filter #(
  parameter int unsigned DEBOUNCE_TICKS = 2,
  parameter int unsigned REPEAT_DELAY   = 12,
  parameter int unsigned REPEAT_RATE    = 4,
  parameter bit          REPEAT_EN      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  input  logic inhibit,
  output logic level,
  output logic press
);
  localparam int unsigned DbW = $clog2(DEBOUNCE_TICKS + 1);

  logic           sync1_q, sync2_q, stable_q, active_q, active, rep_fire;
  logic [DbW-1:0] db_cnt_q;

  // An inhibited level is treated as released, so lifting the inhibit re-arms the edge.
  assign active = stable_q & ~inhibit;
  assign level  = stable_q;
  assign press  = (active & ~active_q) | rep_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      active_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      active_q <= active;
      if (tick) begin
        if (sync2_q == stable_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q + 1'b1 == DbW'(DEBOUNCE_TICKS)) begin
          stable_q <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef MOVE_GEN_AUTO_REPEAT_EN
  if (REPEAT_EN) begin : g_repeat
    localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);

    logic [HoldW-1:0] hold_q, hold_inc, hold_thr;
    logic             rate_phase_q;

    // First repeat after REPEAT_DELAY ticks, then the counter restarts against REPEAT_RATE.
    assign hold_inc = hold_q + 1'b1;
    assign hold_thr = rate_phase_q ? HoldW'(REPEAT_RATE) : HoldW'(REPEAT_DELAY);
    assign rep_fire = active & tick & (hold_inc == hold_thr);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q       <= '0;
        rate_phase_q <= 1'b0;
      end else if (!active) begin
        hold_q       <= '0;
        rate_phase_q <= 1'b0;
      end else if (tick) begin
        if (hold_inc == hold_thr) begin
          hold_q       <= '0;
          rate_phase_q <= 1'b1;
        end else begin
          hold_q <= hold_inc;
        end
      end
    end
  end else begin : g_no_repeat
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE};
    assign rep_fire      = 1'b0;
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_RATE, REPEAT_EN};
  assign rep_fire      = 1'b0;
`endif

endmodule

// File: rtl/move_gen.sv
// Command source for the falling-piece datapath: filtered buttons and gravity feed pending
// flags; a two-state FSM issues one held move_t per ack. Auto-repeat needs MOVE_GEN_AUTO_REPEAT_EN.
module move_gen
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 2,
  parameter int unsigned REPEAT_DELAY   = 12,
  parameter int unsigned REPEAT_RATE    = 4,
  parameter int unsigned GRAVITY_DIV    = 30
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  btn_left,
  input  logic  btn_right,
  input  logic  btn_rotate,
  input  logic  btn_down,
  input  logic  pause,
  input  logic  ack,
  output logic  en,
  output move_t movement
);
  localparam int unsigned GravW = $clog2(GRAVITY_DIV + 1);

  logic             rot_press, left_press, right_press, down_press;
  logic             rot_level, left_level, right_level, down_level;
  logic             unused_levels;
  logic [GravW-1:0] grav_q;
  logic             grav_hit;
  pend_t            pend_q, pend_d, pend_set, pend_clr;
  mg_state_t        state_q, state_d;
  move_t            mov_q, mov_d;
  logic             en_q, en_d;

  btn_filter #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)
  ) u_rotate (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_rotate), .inhibit(1'b0),
    .level(rot_level), .press(rot_press)
  );

  btn_filter #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_left (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_left), .inhibit(right_level),
    .level(left_level), .press(left_press)
  );

  btn_filter #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_right (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_right), .inhibit(left_level),
    .level(right_level), .press(right_press)
  );

  btn_filter #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_down (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn(btn_down), .inhibit(1'b0),
    .level(down_level), .press(down_press)
  );

  assign unused_levels = rot_level ^ down_level;

  assign grav_hit = tick & ~pause & (grav_q == GravW'(GRAVITY_DIV - 1));

  always_comb begin
    pend_set = '0;
    if (!pause) begin
      pend_set.rotate = rot_press;
      pend_set.left   = left_press;
      pend_set.right  = right_press;
      pend_set.down   = down_press | grav_hit;
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mov_d    = mov_q;
    pend_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (pend_q != '0) begin
          mov_d    = pick_move(pend_q);
          en_d     = 1'b1;
          pend_clr = move_mask(mov_d);
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (ack) begin
          en_d    = 1'b0;
          mov_d   = NONE;
          state_d = StIdle;
        end
      end
    endcase
    // A set landing on the cycle its flag is issued survives the clear.
    pend_d = pend_t'((pend_q & ~pend_clr) | pend_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grav_q  <= '0;
      pend_q  <= '0;
      state_q <= StIdle;
      en_q    <= 1'b0;
      mov_q   <= NONE;
    end else begin
      if (tick && !pause) grav_q <= grav_hit ? '0 : grav_q + 1'b1;
      pend_q  <= pend_d;
      state_q <= state_d;
      en_q    <= en_d;
      mov_q   <= mov_d;
    end
  end

  assign en       = en_q;
  assign movement = mov_q;

endmodule

// File: tb/tb_move_gen.sv
// Scoreboard bench for move_gen: directed button/tick/pause stimulus pushes the expected
// command order; a monitor pops one entry per en rising edge and checks hold/idle values.
module tb_move_gen;
  import tetris_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  tick = 1'b0;
  logic  btn_left = 1'b0, btn_right = 1'b0, btn_rotate = 1'b0, btn_down = 1'b0;
  logic  pause = 1'b0;
  logic  ack;
  logic  en;
  move_t movement;

  move_t exp_q[$];
  move_t exp_mov, cur_mov;
  logic  en_prev = 1'b0;
  int    n_tests = 0;
  int    n_fails = 0;
  int    ack_delay = 0;
  int    en_cycles = 0;

  move_gen #(
    .DEBOUNCE_TICKS(2), .REPEAT_DELAY(3), .REPEAT_RATE(2), .GRAVITY_DIV(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_left(btn_left), .btn_right(btn_right),
    .btn_rotate(btn_rotate), .btn_down(btn_down), .pause(pause), .ack(ack),
    .en(en), .movement(movement)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One tick strobe every 4 cycles.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
      tick = 1'b0;
      cycle();
      cycle();
      cycle();
    end
  endtask

  task automatic reset_dut();
    btn_left = 1'b0; btn_right = 1'b0; btn_rotate = 1'b0; btn_down = 1'b0;
    pause = 1'b0; tick = 1'b0;
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic drained(input string name);
    repeat (4) cycle();
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Ack driver: ack_delay 0 ties ack high, otherwise ack rises after en has been high that long.
  initial begin
    int hold;
    hold = 0;
    ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ack_delay == 0) begin
        ack = 1'b1;
      end else begin
        hold = en ? hold + 1 : 0;
        ack = en && (hold >= ack_delay);
      end
    end
  end

  // Monitor: new command pops the scoreboard; held command must not change; idle shows NONE.
  initial begin
    forever begin
      @(negedge clk);
      if (en) en_cycles++;
      n_tests++;
      if (en && !en_prev) begin
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL cmd_unexpected: got %s, required no command", movement.name());
        end else begin
          exp_mov = exp_q.pop_front();
          if (movement !== exp_mov) begin
            n_fails++;
            $display("FAIL cmd_order: got %s, required %s", movement.name(), exp_mov.name());
          end
        end
        cur_mov = movement;
      end else if (en) begin
        if (movement !== cur_mov) begin
          n_fails++;
          $display("FAIL cmd_hold: got %s, required %s", movement.name(), cur_mov.name());
        end
      end else if (movement !== NONE) begin
        n_fails++;
        $display("FAIL idle_none: got %s, required NONE", movement.name());
      end
      en_prev = en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    rst_n = 1'b0;
    cycle();
    cycle();
    check("rst_en", int'(en), 0);
    check("rst_movement", int'(movement), int'(NONE));
    rst_n = 1'b1;
    cycle();

    // 1: rotate tap, ack tied high -> one ROTATE, en for a single cycle
    en_cycles = 0;
    exp_q.push_back(ROTATE);
    btn_rotate = 1'b1;
    do_ticks(3);
    btn_rotate = 1'b0;
    do_ticks(1);
    drained("t1_drain");
    check("t1_en_cycles", en_cycles, 1);

    // 2: hold left; press accepted at tick 3, gravity at ticks 5/10/15
    reset_dut();
`ifdef MOVE_GEN_AUTO_REPEAT_EN
    exp_q.push_back(LEFT); exp_q.push_back(DOWN); exp_q.push_back(LEFT);
    exp_q.push_back(LEFT); exp_q.push_back(LEFT); exp_q.push_back(DOWN);
    exp_q.push_back(LEFT); exp_q.push_back(LEFT); exp_q.push_back(DOWN);
`else
    exp_q.push_back(LEFT); exp_q.push_back(DOWN); exp_q.push_back(DOWN);
    exp_q.push_back(DOWN);
`endif
    btn_left = 1'b1;
    do_ticks(15);
    btn_left = 1'b0;
    drained("t2_hold_left");

    // 3: gravity every 5 ticks; pause at count 2 holds it, DOWN on 3rd tick after resume
    reset_dut();
    exp_q.push_back(DOWN); exp_q.push_back(DOWN);
    do_ticks(12);
    drained("t3_gravity");
    pause = 1'b1;
    do_ticks(10);
    pause = 1'b0;
    do_ticks(2);
    drained("t3_paused");
    exp_q.push_back(DOWN);
    do_ticks(1);
    drained("t3_resume");

    // 4: simultaneous rotate/left/down with 3-cycle ack delay
    reset_dut();
    ack_delay = 3;
    en_cycles = 0;
    exp_q.push_back(ROTATE); exp_q.push_back(LEFT); exp_q.push_back(DOWN);
    btn_rotate = 1'b1; btn_left = 1'b1; btn_down = 1'b1;
    do_ticks(3);
    repeat (30) cycle();
    btn_rotate = 1'b0; btn_left = 1'b0; btn_down = 1'b0;
    drained("t4_priority");
    check("t4_en_cycles", en_cycles, 9);
    ack_delay = 0;

    // 5: left+right blocked; gravity DOWN at tick 5, LEFT once right settles low
    reset_dut();
    exp_q.push_back(DOWN); exp_q.push_back(LEFT);
    btn_left = 1'b1; btn_right = 1'b1;
    do_ticks(4);
    check("t5_blocked", exp_q.size(), 2);
    btn_right = 1'b0;
    do_ticks(3);
    btn_left = 1'b0;
    drained("t5_release_right");

    // 6: reset while a command is held
    reset_dut();
    ack_delay = 1000;
    exp_q.push_back(ROTATE);
    btn_rotate = 1'b1;
    do_ticks(3);
    btn_rotate = 1'b0;
    n = 0;
    while (!en && n < 50) begin
      cycle();
      n++;
    end
    check("t6_en_before_reset", int'(en), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", int'(en), 0);
    check("t6_rst_movement", int'(movement), int'(NONE));
    cycle();
    cycle();
    rst_n = 1'b1;
    ack_delay = 0;
    cycle();
    do_ticks(4);
    drained("t6_quiet");
    exp_q.push_back(DOWN);
    do_ticks(1);
    drained("t6_gravity");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/move_gen.md
# move_gen

Sequential command source for the falling-piece datapath. Converts raw player buttons and a frame strobe into a stream of single `move_t` commands (`en` + `movement`) for the combinational reference-position updater. It handles synchronisation, debounce, auto-repeat, gravity, and arbitration. Each command is held until the consumer acknowledges it.

## Interface
- `DEBOUNCE_TICKS`, 2: consecutive `tick` samples a button level must hold before it is accepted.
- `REPEAT_DELAY`, 12: ticks of continuous hold before the first auto-repeat.
- `REPEAT_RATE`, 4: ticks between subsequent auto-repeats.
- `GRAVITY_DIV`, 30: ticks between gravity DOWN requests; must be ≥1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle frame strobe. All timing counters advance only on `tick`.
- `btn_left`, `btn_right`, `btn_rotate`, `btn_down` in 1 each: raw asynchronous buttons, active-high.
- `pause` in 1: freezes gravity and discards new requests.
- `ack` in 1: consumer accepted the current command.
- `en` out 1: command valid.
- `movement` out `move_t`: command; NONE whenever `en`=0.

## Operation
- Each button passes through a 2-flop synchroniser. A per-button debounce counter then updates the stable level only after `DEBOUNCE_TICKS` equal consecutive `tick` samples.
- A 0→1 edge of a stable level sets that button's pending flag.
- Auto-repeat applies to left, right and down only; rotate never repeats. While the stable level is 1, a per-button hold counter counts ticks.
  - The flag is set again at hold = `REPEAT_DELAY`, then every `REPEAT_RATE` ticks.
  - Release resets the hold counter.
- Left and right are both stable-high: neither sets or repeats, and both hold counters reset.
- Gravity: the tick counter wraps at `GRAVITY_DIV`-1 and sets pending DOWN. A soft-drop DOWN and a gravity DOWN that are both pending merge into one DOWN.
- `pause`=1: the gravity counter holds its value and new flag sets are suppressed. Already-pending flags and any outstanding command are still issued.
- FSM has two states:
  - IDLE: if any flag is pending, select by priority ROTATE > LEFT > RIGHT > DOWN. Register `movement`, set `en`=1, clear the selected flag, and go to ISSUE.
  - ISSUE: `en` and `movement` are held stable. When `ack`=1, go to IDLE with `en`=0 and `movement`=NONE.
- A flag set in the same cycle it is cleared by issue remains set, so the set wins.
- Reset, asynchronous at any time including mid-ISSUE:
  - `en`=0, `movement`=NONE, FSM in IDLE.
  - All flags, debounce, hold and gravity counters are 0; synchronisers and stable levels are 0.
  - No command is replayed after reset.

## Timing
- Button to pending flag takes 2 cycles of synchronisation, plus `DEBOUNCE_TICKS` ticks, plus 1 cycle.
- Pending flag to `en`=1 is 1 cycle when in IDLE.
- `ack` sampled high means `en`=0 in the next cycle.
- Minimum gap between commands is one cycle with `en`=0, so back-to-back issue gives at most one command every 2 cycles.
- `ack` while `en`=0 is ignored.
- A gravity flag set while in ISSUE waits. A gravity flag set again before it is issued is lost (merged), never queued.

## Configuration
- `MOVE_GEN_AUTO_REPEAT_EN` defined: auto-repeat as specified above.
- Undefined: hold counters are removed, `REPEAT_DELAY`/`REPEAT_RATE` are ignored, and each stable press yields exactly one command. Gravity is unaffected.

## Structure
- `tetris_pkg` owns the `move_t` enum (RIGHT, LEFT, ROTATE, DOWN, NONE) and the FSM state enum `mg_state_t`.
- `move_gen` uses enum names only, never literal encodings.
- One sub-module, `btn_filter`: synchroniser, debounce and hold/repeat counter for one button, outputting a one-cycle `press` pulse. It is instantiated 4 times, with repeat tied off for rotate.

## Test plan
Parameters are `DEBOUNCE_TICKS`=2, `REPEAT_DELAY`=3, `REPEAT_RATE`=2, `GRAVITY_DIV`=5, and `tick` every 4 cycles.
1. Tap `btn_rotate` for 3 ticks with `ack` tied high: exactly one ROTATE with `en` high for 1 cycle. `movement`=NONE otherwise.
2. Hold `btn_left` for 12 ticks with auto-repeat on: LEFT on press, then at hold ticks 3, 5, 7, 9, 11. With the macro undefined: a single LEFT.
3. Idle buttons, `ack`=1: DOWN every 5 ticks. With `pause`=1 for 10 ticks, there is no DOWN and gravity resumes from the held count.
4. Press rotate, left and down in the same cycle with `ack` delayed 3 cycles: order is ROTATE, LEFT, DOWN. `movement` is stable while `en`=1, with an `en`=0 gap after each `ack`.
5. Hold left and right together: no LEFT/RIGHT issued. Release right: LEFT issues.
6. Assert `rst_n`=0 mid-ISSUE while `en`=1: `en`=0 and `movement`=NONE immediately. After release, no command until a new press or a full gravity period.
